rca_pipe_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It succeeds the fixed 40-bit combinational ripple adder and adds:
- operand width and pipeline depth as parameters;
- add/subtract mode with borrow-in;
- signed-overflow detection;
- a valid/ready handshake with backpressure.

It sits on the datapath between operand registers and the result bus, so wide sums close timing at a fixed multi-cycle latency with full throughput.

---
 rtl/rca_pipe_addsub.sv | 144 ++++++++++++++
 tb/tb_rca_pipe_addsub.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub: pipelined ripple-carry adder/subtractor with valid/ready.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready - operand beat handshake (A, B, Cin, sub)
//   out_valid/out_ready - result beat handshake (S, Cout, V)
//   A, B   [WIDTH]      - operands
//   Cin                 - carry-in (add) / borrow-in (sub)
//   sub                 - 0 = A+B+Cin, 1 = A-B-Cin
//   S      [WIDTH]      - result modulo 2^WIDTH
//   Cout                - carry-out (add) / not-borrow (sub)
//   V                   - signed overflow
module rca_pipe_addsub #(
    parameter int WIDTH  = 40,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int SW     = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST_W = WIDTH - (STAGES - 1) * SW;

    if (WIDTH < 2) begin : g_err_width
        $error("rca_pipe_addsub: WIDTH must be >= 2");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_err_stages
        $error("rca_pipe_addsub: STAGES must be in 1..WIDTH");
    end
    if (LAST_W < 1) begin : g_err_slice
        $error("rca_pipe_addsub: last slice would be empty");
    end

    // Whole pipeline advances as one; it only stalls when a result
    // is waiting and downstream refuses it.
    logic en;
    assign en       = ~out_valid | out_ready;
    // Reset forces ready high; the reset branch below still drops the beat.
    assign in_ready = reset | en;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SW;
        localparam int HI = (k == STAGES - 1) ? WIDTH - 1 : LO + SW - 1;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic             c_in;
        logic             c_nx;
        logic             vld_in;

        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             vld_q;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + ~Cin.
            assign a_in   = A;
            assign b_in   = sub ? ~B : B;
            assign s_in   = '0;
            assign c_in   = Cin ^ sub;
            assign vld_in = in_valid;
        end else begin : g_src
            assign a_in   = g_st[k-1].g_skew.a_q;
            assign b_in   = g_st[k-1].g_skew.b_q;
            assign s_in   = g_st[k-1].s_q;
            assign c_in   = g_st[k-1].c_q;
            assign vld_in = g_st[k-1].vld_q;
        end

        // Ripple through this slice; lower result bits pass straight
        // through (de-skew), upper bits are filled by later stages.
        always_comb begin
            s_nx = s_in;
            c_nx = c_in;
            for (int i = LO; i <= HI; i++) begin
                s_nx[i] = a_in[i] ^ b_in[i] ^ c_nx;
                c_nx    = (a_in[i] & b_in[i])
                        | (a_in[i] & c_nx)
                        | (b_in[i] & c_nx);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
            end else if (en) begin
                vld_q <= vld_in;
                s_q   <= s_nx;
                c_q   <= c_nx;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // Operands still needed by the upper slices.
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end else begin : g_out
            // Overflow: operands share a sign and the result differs.
            logic v_nx;
            logic v_q;

            assign v_nx = (a_in[WIDTH-1] ~^ b_in[WIDTH-1])
                        & (s_nx[WIDTH-1] ^ a_in[WIDTH-1]);

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_nx;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign S         = g_st[STAGES-1].s_q;
    assign Cout      = g_st[STAGES-1].c_q;
    assign V         = g_st[STAGES-1].g_out.v_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb_rca_pipe_addsub: directed and streaming checks of rca_pipe_addsub
// at 40/4, plus random sweeps at 37/5 and 8/1.
module tb_rca_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        m_iv, m_ir, m_ov, m_or, m_cin, m_sub, m_co, m_v;
    logic [39:0] m_a, m_b, m_s;
    logic        p_iv, p_ir, p_ov, p_or, p_cin, p_sub, p_co, p_v;
    logic [36:0] p_a, p_b, p_s;
    logic        q_iv, q_ir, q_ov, q_or, q_cin, q_sub, q_co, q_v;
    logic [7:0]  q_a, q_b, q_s;

    rca_pipe_addsub #(.WIDTH(40), .STAGES(4)) u_main (
        .clk(clk), .reset(reset),
        .in_valid(m_iv), .in_ready(m_ir),
        .A(m_a), .B(m_b), .Cin(m_cin), .sub(m_sub),
        .out_valid(m_ov), .out_ready(m_or),
        .S(m_s), .Cout(m_co), .V(m_v)
    );

    rca_pipe_addsub #(.WIDTH(37), .STAGES(5)) u_w37 (
        .clk(clk), .reset(reset),
        .in_valid(p_iv), .in_ready(p_ir),
        .A(p_a), .B(p_b), .Cin(p_cin), .sub(p_sub),
        .out_valid(p_ov), .out_ready(p_or),
        .S(p_s), .Cout(p_co), .V(p_v)
    );

    rca_pipe_addsub #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .reset(reset),
        .in_valid(q_iv), .in_ready(q_ir),
        .A(q_a), .B(q_b), .Cin(q_cin), .sub(q_sub),
        .out_valid(q_ov), .out_ready(q_or),
        .S(q_s), .Cout(q_co), .V(q_v)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide integer addition, result {V, Cout, S}.
    function automatic logic [41:0] model(input logic [39:0] a,
                                          input logic [39:0] b,
                                          input logic cin,
                                          input logic sb,
                                          input int w);
        logic [63:0] mask, aa, bb, full, s;
        logic        co, v;
        mask = (64'd1 << w) - 64'd1;
        aa   = {24'd0, a} & mask;
        bb   = sb ? (~{24'd0, b}) & mask : {24'd0, b} & mask;
        full = aa + bb + {63'd0, sb ? ~cin : cin};
        s    = full & mask;
        co   = full[w];
        v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {v, co, s[39:0]};
    endfunction

    task automatic run_one(input string tag,
                           input logic [39:0] a, input logic [39:0] b,
                           input logic ci, input logic sb,
                           input logic [39:0] es,
                           input logic ec, input logic ev);
        int lat;
        m_a = a; m_b = b; m_cin = ci; m_sub = sb;
        m_iv = 1'b1; m_or = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        lat = 1;
        while (!m_ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd4);
        chk({tag, "_s"}, 64'(m_s), 64'(es));
        chk({tag, "_cout"}, 64'(m_co), 64'(ec));
        chk({tag, "_v"}, 64'(m_v), 64'(ev));
        @(posedge clk); #1;
    endtask

    logic [39:0] st_a [16];
    logic [39:0] st_b [16];
    logic        st_c [16];
    logic        st_s [16];

    initial begin
        logic [41:0] exp_q [$];
        logic [41:0] pq [$];
        logic [41:0] qq [$];
        int          pt [$];
        int          qt [$];
        logic [41:0] got, e;
        logic [63:0] r;
        logic        acc, cons, exp_r, pacc, qacc;
        int          sent, rcv, cyc, cnt, ps, pr, qs, qr, st;

        reset = 1'b1;
        m_iv = 1'b0; m_or = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
        p_iv = 1'b0; p_or = 1'b1; p_a = '0; p_b = '0; p_cin = 1'b0; p_sub = 1'b0;
        q_iv = 1'b0; q_or = 1'b1; q_a = '0; q_b = '0; q_cin = 1'b0; q_sub = 1'b0;

        @(posedge clk); #1;
        chk("rst_ready", 64'(m_ir), 64'd1);
        @(posedge clk); #1;
        chk("rst_ovalid", 64'(m_ov), 64'd0);
        chk("rst_s", 64'(m_s), 64'd0);
        chk("rst_cout", 64'(m_co), 64'd0);
        chk("rst_v", 64'(m_v), 64'd0);
        chk("rst_ovalid37", 64'(p_ov), 64'd0);
        chk("rst_ovalid8", 64'(q_ov), 64'd0);
        reset = 1'b0;
        m_or = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run_one("add_small", 40'h00_0000_0003, 40'h00_0000_0004, 1'b1, 1'b0,
                40'h00_0000_0008, 1'b0, 1'b0);
        run_one("add_wrap", 40'hFF_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b0,
                40'h00_0000_0000, 1'b1, 1'b0);
        run_one("add_ovf", 40'h7F_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b0,
                40'h80_0000_0000, 1'b0, 1'b1);
        run_one("sub_neg", 40'h00_0000_0005, 40'h00_0000_0007, 1'b0, 1'b1,
                40'hFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_bin", 40'h00_0000_0007, 40'h00_0000_0005, 1'b1, 1'b1,
                40'h00_0000_0001, 1'b1, 1'b0);
        run_one("sub_ovf", 40'h80_0000_0000, 40'h00_0000_0001, 1'b0, 1'b1,
                40'h7F_FFFF_FFFF, 1'b1, 1'b1);

        // Streaming under backpressure
        for (int i = 0; i < 16; i++) begin
            r = {$urandom(), $urandom()};
            st_a[i] = r[39:0];
            r = {$urandom(), $urandom()};
            st_b[i] = r[39:0];
            st_c[i] = 1'($urandom_range(0, 1));
            st_s[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 16 && cyc < 200) begin
            if (cyc < 6)       m_or = 1'b1;
            else if (cyc < 10) m_or = 1'b0;
            else               m_or = 1'($urandom_range(0, 1));
            m_iv = (sent < 16);
            if (sent < 16) begin
                m_a = st_a[sent]; m_b = st_b[sent];
                m_cin = st_c[sent]; m_sub = st_s[sent];
            end
            #2;
            exp_r = ~m_ov | m_or;
            chk("stream_ready", 64'(m_ir), 64'(exp_r));
            acc  = m_iv && m_ir;
            cons = m_ov && m_or;
            got  = {m_v, m_co, m_s};
            @(posedge clk); #1;
            cyc++;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d", rcv), 64'(got), 64'(e));
                end
                rcv++;
            end
            if (acc) begin
                exp_q.push_back(model(st_a[sent], st_b[sent],
                                      st_c[sent], st_s[sent], 40));
                sent++;
            end
        end
        chk("stream_count", 64'(rcv), 64'd16);
        m_iv = 1'b0; m_or = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_idle", 64'(m_ov), 64'd0);

        // Reset with three beats in flight
        m_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_a = 40'(i + 10); m_b = 40'd1; m_cin = 1'b0; m_sub = 1'b0;
            m_iv = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        m_a = 40'd1; m_b = 40'd1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_iv = 1'b0;
        chk("midrst_ovalid", 64'(m_ov), 64'd0);
        chk("midrst_s", 64'(m_s), 64'd0);
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (m_ov) cnt++;
        end
        chk("midrst_stale", 64'(cnt), 64'd0);
        run_one("after_rst", 40'h12_3456_789A, 40'h01_1111_1111, 1'b0, 1'b0,
                40'h13_4567_89AB, 1'b0, 1'b0);

        // Parameter sweep: 37/5 and 8/1 run side by side
        p_or = 1'b1; q_or = 1'b1;
        ps = 0; pr = 0; qs = 0; qr = 0; cyc = 0;
        while ((pr < 1000 || qr < 1000) && cyc < 3000) begin
            p_iv = (ps < 1000) && ($urandom_range(0, 7) != 0);
            r = {$urandom(), $urandom()};
            p_a = r[36:0];
            r = {$urandom(), $urandom()};
            p_b = r[36:0];
            p_cin = 1'($urandom_range(0, 1));
            p_sub = 1'($urandom_range(0, 1));
            q_iv = (qs < 1000) && ($urandom_range(0, 7) != 0);
            q_a = 8'($urandom_range(0, 255));
            q_b = 8'($urandom_range(0, 255));
            q_cin = 1'($urandom_range(0, 1));
            q_sub = 1'($urandom_range(0, 1));
            #2;
            if (p_ov) begin
                if (pq.size() == 0) begin
                    chk("w37_extra", 64'd1, 64'd0);
                end else begin
                    e = pq.pop_front();
                    st = pt.pop_front();
                    chk($sformatf("w37_res%0d", pr),
                        64'({p_v, p_co, 3'b000, p_s}), 64'(e));
                    chk($sformatf("w37_lat%0d", pr), 64'(cyc - st), 64'd5);
                end
                pr++;
            end
            if (q_ov) begin
                if (qq.size() == 0) begin
                    chk("w8_extra", 64'd1, 64'd0);
                end else begin
                    e = qq.pop_front();
                    st = qt.pop_front();
                    chk($sformatf("w8_res%0d", qr),
                        64'({q_v, q_co, 32'd0, q_s}), 64'(e));
                    chk($sformatf("w8_lat%0d", qr), 64'(cyc - st), 64'd1);
                end
                qr++;
            end
            pacc = p_iv && p_ir;
            qacc = q_iv && q_ir;
            @(posedge clk); #1;
            if (pacc) begin
                pq.push_back(model(40'(p_a), 40'(p_b), p_cin, p_sub, 37));
                pt.push_back(cyc);
                ps++;
            end
            if (qacc) begin
                qq.push_back(model(40'(q_a), 40'(q_b), q_cin, q_sub, 8));
                qt.push_back(cyc);
                qs++;
            end
            cyc++;
        end
        chk("w37_count", 64'(pr), 64'd1000);
        chk("w8_count", 64'(qr), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
